id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) of the 5-stage RV32I core, with built-in load-use hazard detection.
- Supplies rs1/rs2/rd and the register-write enable that the EX-stage forwarding logic compares against.
- Inserts bubbles on load-use hazards and branch/jump flushes, and holds its contents on downstream stalls.

Parameters:
- XLEN, 32, datapath width (pc, operands, immediate)
- ALUOP_W, 4, width of ALU operation code

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_pc  input  XLEN  instruction PC
- id_rs1  input  5  source register 1 index
- id_rs2  input  5  source register 2 index
- id_rd  input  5  destination register index
- id_uses_rs1  input  1  instruction reads rs1
- id_uses_rs2  input  1  instruction reads rs2
- id_rs1_data  input  XLEN  register file read data 1
- id_rs2_data  input  XLEN  register file read data 2
- id_imm  input  XLEN  decoded immediate
- id_load_enable  input  1  register write enable
- id_mem_read  input  1  load instruction
- id_mem_write  input  1  store instruction
- id_alu_op  input  ALUOP_W  ALU operation
- id_alu_src  input  1  ALU operand B selects immediate
- id_branch  input  1  conditional branch
- id_jump  input  1  JAL/JALR
- flush_ex  input  1  taken branch/jump resolved in EX; kill the ID instruction
- hold_ex  input  1  downstream (MEM) stall; freeze this stage
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_load_enable, ex_mem_read, ex_mem_write, ex_alu_op, ex_alu_src, ex_branch, ex_jump  output  (widths as the matching id_ input)  registered EX-stage copies
- stall_if_id  output  1  combinational; hold the PC and the IF/ID register this cycle

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, giving a bubble. stall_if_id is 0 while in reset.
- Load-use hazard (combinational), luh = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall_if_id = hold_ex | (luh & ~flush_ex).
- Register update at each rising edge, first match wins:
  1. hold_ex = 1: all registers keep their value, including a pending bubble. A flush_ex or luh presented during hold has no effect that cycle; both remain derived from the held contents and re-evaluate once hold_ex drops.
  2. flush_ex = 1: load a bubble.
  3. luh = 1: load a bubble. The ID instruction stays in IF/ID and is captured one cycle later, when luh is 0 because EX holds the bubble.
  4. Otherwise: capture every id_ input. ex_valid = id_valid.
- Bubble definition: valid, all control bits, alu_op, rs1, rs2 and rd are 0; pc, data and imm are 0. A bubble therefore never matches in forwarding and never writes.
- Invalid input (id_valid = 0, normal load): control fields are captured as 0, whatever the id_ control inputs carry.
- Load-use penalty is exactly one bubble cycle per hazard.
- Back-to-back hazards each insert one bubble.
- rd = 0 never causes a stall.
- Latency: 1 cycle from ID input to EX output.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs luh_cnt[31:0] and flush_cnt[31:0].
  - luh_cnt increments on each edge where rule 3 applies.
  - flush_cnt increments on each edge where rule 2 applies.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and do not count while hold_ex = 1.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: drive a valid ADD, pulse rst_n low between clock edges -> all ex_ outputs 0 immediately (asynchronous), stall_if_id = 0.
- Load-use: EX holds LW with rd = x5; ID holds ADD with rs1 = x5, id_uses_rs1 = 1 -> stall_if_id = 1 for one cycle; next cycle ex_valid = 0 and ex_rd = 0; following cycle ex_rd = the ADD's rd with ex_valid = 1.
- No false stall:
  - LW rd = x0 followed by ADD rs1 = x0 -> stall_if_id = 0.
  - LW rd = x5 followed by LUI (id_uses_rs1 = 0, id_uses_rs2 = 0) -> stall_if_id = 0.
- Flush priority: flush_ex = 1 together with luh = 1 -> stall_if_id = 0; next cycle bubble; luh_cnt unchanged, flush_cnt + 1.
- Hold: hold_ex = 1 for 3 cycles with ex_pc = 0x100 -> ex_pc stays 0x100 and stall_if_id = 1 all 3 cycles; new ID contents are captured on the first edge after hold_ex drops.
- Counter saturation (HAZARD_PERF_CNT_EN): force luh_cnt to 32'hFFFF_FFFF via backdoor, trigger a load-use -> counter stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core. It detects load-use hazards, inserts bubbles and holds on downstream stalls.
// Define HAZARD_PERF_CNT_EN to add saturating load-use and flush event counters (luh_cnt, flush_cnt).
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_load_enable,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic               flush_ex,
    input  logic               hold_ex,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic               ex_load_enable,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               stall_if_id
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        luh_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic               load_enable;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               branch;
        logic               jump;
    } stage_t;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_FLUSH,
        UPD_BUBBLE,
        UPD_LOAD
    } upd_e;

    stage_t stage_q;
    stage_t stage_d;
    stage_t captured;
    upd_e   upd;
    logic   luh;

    // EX holds a load whose nonzero destination the ID instruction actually reads.
    assign luh = stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == stage_q.rd)) ||
                  (id_uses_rs2 && (id_rs2 == stage_q.rd)));

    assign stall_if_id = rst_n && (hold_ex || (luh && !flush_ex));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        captured             = '0;
        captured.valid       = id_valid;
        captured.pc          = id_pc;
        captured.rs1         = id_rs1;
        captured.rs2         = id_rs2;
        captured.rd          = id_rd;
        captured.rs1_data    = id_rs1_data;
        captured.rs2_data    = id_rs2_data;
        captured.imm         = id_imm;
        if (id_valid) begin
            captured.load_enable = id_load_enable;
            captured.mem_read    = id_mem_read;
            captured.mem_write   = id_mem_write;
            captured.alu_op      = id_alu_op;
            captured.alu_src     = id_alu_src;
            captured.branch      = id_branch;
            captured.jump        = id_jump;
        end

        if (hold_ex)       upd = UPD_HOLD;
        else if (flush_ex) upd = UPD_FLUSH;
        else if (luh)      upd = UPD_BUBBLE;
        else               upd = UPD_LOAD;

        case (upd)
            UPD_HOLD: stage_d = stage_q;
            UPD_LOAD: stage_d = captured;
            default:  stage_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    assign ex_valid       = stage_q.valid;
    assign ex_pc          = stage_q.pc;
    assign ex_rs1         = stage_q.rs1;
    assign ex_rs2         = stage_q.rs2;
    assign ex_rd          = stage_q.rd;
    assign ex_rs1_data    = stage_q.rs1_data;
    assign ex_rs2_data    = stage_q.rs2_data;
    assign ex_imm         = stage_q.imm;
    assign ex_load_enable = stage_q.load_enable;
    assign ex_mem_read    = stage_q.mem_read;
    assign ex_mem_write   = stage_q.mem_write;
    assign ex_alu_op      = stage_q.alu_op;
    assign ex_alu_src     = stage_q.alu_src;
    assign ex_branch      = stage_q.branch;
    assign ex_jump        = stage_q.jump;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luh_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (upd == UPD_BUBBLE && luh_cnt != 32'hFFFF_FFFF)
                luh_cnt <= luh_cnt + 32'd1;
            if (upd == UPD_FLUSH && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/reset cases plus a randomized run against a pipeline model.
// Counter checks are compiled when HAZARD_PERF_CNT_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_load_enable, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_branch, id_jump;
    logic        flush_ex, hold_ex;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic        ex_load_enable, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_branch, ex_jump;
    logic        stall_if_id;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] luh_cnt, flush_cnt;
    bit   [31:0] m_lcnt, m_fcnt;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_load_enable(id_load_enable), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .flush_ex(flush_ex), .hold_ex(hold_ex),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_load_enable(ex_load_enable), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .stall_if_id(stall_if_id)
`ifdef HAZARD_PERF_CNT_EN
        , .luh_cnt(luh_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Expected contents of the EX stage, as an instruction record.
    typedef struct packed {
        bit        valid;
        bit [31:0] pc;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit        we, mr, mw;
        bit [3:0]  op;
        bit        src, br, jmp;
    } instr_t;

    instr_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A stall is needed when the instruction in EX is a load to a real register that ID reads.
    function automatic bit model_luh();
        bit reads_it;
        reads_it = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return m.valid && m.mr && m.rd != 0 && id_valid && reads_it;
    endfunction

    function automatic bit model_stall();
        if (!rst_n) return 1'b0;
        return hold_ex || (model_luh() && !flush_ex);
    endfunction

    task automatic model_edge();
        instr_t n;
        if (!rst_n || hold_ex) return;
        n = '0;
        if (flush_ex) begin
`ifdef HAZARD_PERF_CNT_EN
            if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
`endif
        end else if (model_luh()) begin
`ifdef HAZARD_PERF_CNT_EN
            if (m_lcnt != 32'hFFFF_FFFF) m_lcnt = m_lcnt + 1;
`endif
        end else begin
            n.valid = id_valid; n.pc = id_pc;
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
            if (id_valid) begin
                n.we = id_load_enable; n.mr = id_mem_read; n.mw = id_mem_write;
                n.op = id_alu_op; n.src = id_alu_src; n.br = id_branch; n.jmp = id_jump;
            end
        end
        m = n;
    endtask

    task automatic model_reset();
        m = '0;
`ifdef HAZARD_PERF_CNT_EN
        m_lcnt = 0;
        m_fcnt = 0;
`endif
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_pc"},   64'(ex_pc), 64'(m.pc));
        check({tag, "_data"}, {ex_rs1_data, ex_rs2_data}, {m.d1, m.d2});
        check({tag, "_imm"},  64'(ex_imm), 64'(m.imm));
        check({tag, "_ctrl"},
              64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_load_enable, ex_mem_read, ex_mem_write,
                   ex_alu_op, ex_alu_src, ex_branch, ex_jump}),
              64'({m.valid, m.rs1, m.rs2, m.rd, m.we, m.mr, m.mw, m.op, m.src, m.br, m.jmp}));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_luh_cnt"},   64'(luh_cnt),   64'(m_lcnt));
        check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_fcnt));
`endif
    endtask

    // Called shortly after the falling edge: checks the stall, crosses one rising edge, checks the registers.
    task automatic tick(input string tag);
        #1 check({tag, "_stall"}, 64'(stall_if_id), 64'(model_stall()));
        @(posedge clk);
        model_edge();
        #1 check_regs(tag);
    endtask

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input bit u1, input bit u2, input bit mr, input bit we);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_mem_read = mr; id_load_enable = we;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_mem_write = 1'b0; id_alu_op = 4'($urandom); id_alu_src = mr;
        id_branch = 1'b0; id_jump = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_ex = 1'b0; hold_ex = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2 check_regs("reset");
        check("reset_stall", 64'(stall_if_id), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Load-use: LW x5 then ADD reading x5 -> one bubble, then the ADD.
        @(negedge clk); set_id(1, 32'h40, 1, 0, 5, 1, 0, 1, 1); tick("lw5");
        @(negedge clk); set_id(1, 32'h44, 5, 2, 7, 1, 1, 0, 1);
        #1 check("lu_stall", 64'(stall_if_id), 64'd1);
        tick("lu_bubble");
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_rd", 64'(ex_rd), 64'd0);
        @(negedge clk); tick("lu_add");
        check("lu_add_rd", 64'(ex_rd), 64'd7);
        check("lu_add_valid", 64'(ex_valid), 64'd1);

        // No false stalls: rd = x0, and an instruction that reads nothing.
        @(negedge clk); set_id(1, 32'h48, 0, 0, 0, 0, 0, 1, 1); tick("lw0");
        @(negedge clk); set_id(1, 32'h4c, 0, 0, 6, 1, 1, 0, 1);
        #1 check("x0_stall", 64'(stall_if_id), 64'd0);
        tick("add_x0");
        @(negedge clk); set_id(1, 32'h50, 3, 0, 5, 1, 0, 1, 1); tick("lw5b");
        @(negedge clk); set_id(1, 32'h54, 5, 5, 8, 0, 0, 0, 1);
        #1 check("lui_stall", 64'(stall_if_id), 64'd0);
        tick("lui");

        // Flush beats a simultaneous load-use.
        @(negedge clk); set_id(1, 32'h58, 0, 0, 5, 0, 0, 1, 1); tick("lw5c");
        @(negedge clk); set_id(1, 32'h5c, 5, 0, 9, 1, 0, 0, 1); flush_ex = 1'b1;
        #1 check("flush_stall", 64'(stall_if_id), 64'd0);
        tick("flush");
        check("flush_valid", 64'(ex_valid), 64'd0);
        flush_ex = 1'b0;

        // Hold three cycles: EX keeps pc 0x100 and the stall stays asserted.
        @(negedge clk); set_id(1, 32'h100, 1, 2, 3, 1, 1, 0, 1); tick("pc100");
        hold_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_id(1, 32'h200 + 32'(i * 4), 3, 3, 4, 1, 1, 0, 1);
            #1 check("hold_stall", 64'(stall_if_id), 64'd1);
            tick("hold");
            check("hold_pc", 64'(ex_pc), 64'h100);
        end
        @(negedge clk); hold_ex = 1'b0; set_id(1, 32'h300, 1, 1, 2, 1, 0, 0, 1); tick("unhold");
        check("unhold_pc", 64'(ex_pc), 64'h300);

`ifdef HAZARD_PERF_CNT_EN
        // Saturation: preload luh_cnt to all-ones, then cause a load-use.
        @(negedge clk); set_id(1, 32'h400, 0, 0, 5, 0, 0, 1, 1); tick("lw5d");
        @(negedge clk); set_id(1, 32'h404, 5, 0, 6, 1, 0, 0, 1);
        force dut.luh_cnt = 32'hFFFF_FFFF;
        #1 release dut.luh_cnt;
        m_lcnt = 32'hFFFF_FFFF;
        tick("sat");
        check("sat_luh_cnt", 64'(luh_cnt), 64'hFFFF_FFFF);
`endif

        // Randomized traffic with small register indices so hazards are common.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_id($urandom_range(0, 4) != 0, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            id_mem_write = 1'($urandom); id_branch = 1'($urandom); id_jump = 1'($urandom);
            flush_ex = ($urandom_range(0, 7) == 0);
            hold_ex  = ($urandom_range(0, 6) == 0);
            tick("rand");
        end
        flush_ex = 1'b0; hold_ex = 1'b0;

        // Reset mid-stream: capture a valid ADD, then drop rst_n between edges.
        @(negedge clk); set_id(1, 32'h500, 1, 2, 3, 1, 1, 0, 1); tick("add_pre_rst");
        #2 rst_n = 1'b0; hold_ex = 1'b1;
        model_reset();
        #1 check_regs("async_rst");
        check("async_rst_stall", 64'(stall_if_id), 64'd0);
        @(negedge clk); rst_n = 1'b1; hold_ex = 1'b0;
        tick("post_rst");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
